// File: rtl/mem_access_stage_if.sv
// Bundle between the EX/MEM register, the data-memory port and the MEM/WB register.
// The master drives instructions and memory responses; the slave is the MEM stage itself.
interface mem_access_stage_if #(
   parameter int DATA_WIDTH = 64,
   parameter int RF_SIZE    = 5
);
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   in_pc;
   logic [DATA_WIDTH-1:0]   in_pc_next;
   logic [DATA_WIDTH-1:0]   in_alu_result;
   logic [DATA_WIDTH-1:0]   in_store_data;
   logic [RF_SIZE-1:0]      in_rd;
   logic                    in_reg_wen;
   logic                    in_mem_ren;
   logic                    in_mem_wen;
   logic [2:0]              in_detail;

   logic                    mem_req_valid;
   logic                    mem_req_ready;
   logic [DATA_WIDTH-1:0]   mem_req_addr;
   logic                    mem_req_we;
   logic [DATA_WIDTH-1:0]   mem_req_wdata;
   logic [DATA_WIDTH/8-1:0] mem_req_wmask;
   logic                    mem_rsp_valid;
   logic [DATA_WIDTH-1:0]   mem_rsp_rdata;

   logic                    out_valid;
   logic [DATA_WIDTH-1:0]   out_pc;
   logic [DATA_WIDTH-1:0]   out_pc_next;
   logic [DATA_WIDTH-1:0]   out_wb_data;
   logic [RF_SIZE-1:0]      out_rd;
   logic                    out_reg_wen;
   logic                    out_misalign;

   modport master (
      output in_valid, in_pc, in_pc_next, in_alu_result, in_store_data, in_rd,
             in_reg_wen, in_mem_ren, in_mem_wen, in_detail,
             mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
             out_valid, out_pc, out_pc_next, out_wb_data, out_rd, out_reg_wen, out_misalign
   );

   modport slave (
      input  in_valid, in_pc, in_pc_next, in_alu_result, in_store_data, in_rd,
             in_reg_wen, in_mem_ren, in_mem_wen, in_detail,
             mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
             out_valid, out_pc, out_pc_next, out_wb_data, out_rd, out_reg_wen, out_misalign
   );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: 1 cycle for ALU ops and misaligned accesses, multi-cycle for memory ops.
// in_ready is high only in IDLE; requests are held stable until mem_req_ready.
module mem_access_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int RF_SIZE    = 5
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_stage_if.slave bus
);
   localparam int NBYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] pc_q, pc_next_q, addr_q, wdata_q;
   logic [NBYTES-1:0]     wmask_q;
   logic [RF_SIZE-1:0]    rd_q;
   logic                  reg_wen_q, store_q;
   logic [2:0]            detail_q;

   logic                  out_valid_q, out_reg_wen_q, out_misalign_q;
   logic [DATA_WIDTH-1:0] out_pc_q, out_pc_next_q, out_wb_data_q;
   logic [RF_SIZE-1:0]    out_rd_q;

   logic                  is_mem_d, misalign_d;
   logic [NBYTES-1:0]     wmask_d;
   logic [DATA_WIDTH-1:0] wdata_d, load_d;

   function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] rdata,
                                                          input logic [2:0] off,
                                                          input logic [2:0] detail);
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] res;
      sh = rdata >> {off, 3'b000};
      case (detail[1:0])
         2'd0:    res = detail[2] ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]}
                                  : {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         2'd1:    res = detail[2] ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]}
                                  : {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         2'd2:    res = detail[2] ? {{(DATA_WIDTH-32){1'b0}}, sh[31:0]}
                                  : {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   always_comb begin
      is_mem_d = bus.in_mem_ren | bus.in_mem_wen;
      case (bus.in_detail[1:0])
         2'd0:    begin misalign_d = 1'b0;                           wmask_d = NBYTES'(8'h01); end
         2'd1:    begin misalign_d = bus.in_alu_result[0];           wmask_d = NBYTES'(8'h03); end
         2'd2:    begin misalign_d = |bus.in_alu_result[1:0];        wmask_d = NBYTES'(8'h0F); end
         default: begin misalign_d = |bus.in_alu_result[2:0];        wmask_d = NBYTES'(8'hFF); end
      endcase
      wmask_d = wmask_d << bus.in_alu_result[2:0];
      wdata_d = bus.in_store_data << {bus.in_alu_result[2:0], 3'b000};
      load_d  = load_extract(bus.mem_rsp_rdata, addr_q[2:0], detail_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pc_q           <= '0;
         pc_next_q      <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         wmask_q        <= '0;
         rd_q           <= '0;
         reg_wen_q      <= 1'b0;
         store_q        <= 1'b0;
         detail_q       <= '0;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_pc_next_q  <= '0;
         out_wb_data_q  <= '0;
         out_rd_q       <= '0;
         out_reg_wen_q  <= 1'b0;
         out_misalign_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.in_valid) begin
               pc_q      <= bus.in_pc;
               pc_next_q <= bus.in_pc_next;
               addr_q    <= bus.in_alu_result;
               wdata_q   <= wdata_d;
               wmask_q   <= wmask_d;
               rd_q      <= bus.in_rd;
               reg_wen_q <= bus.in_reg_wen;
               store_q   <= bus.in_mem_wen;
               detail_q  <= bus.in_detail;
               // Misaligned memory ops retire immediately with writeback suppressed.
               if (!is_mem_d || misalign_d) begin
                  out_valid_q    <= 1'b1;
                  out_pc_q       <= bus.in_pc;
                  out_pc_next_q  <= bus.in_pc_next;
                  out_wb_data_q  <= bus.in_alu_result;
                  out_reg_wen_q  <= bus.in_reg_wen & ~is_mem_d;
                  out_rd_q       <= (bus.in_reg_wen && !is_mem_d) ? bus.in_rd : '0;
                  out_misalign_q <= is_mem_d;
               end else begin
                  state_q <= REQ;
               end
            end
            REQ: if (bus.mem_req_ready) begin
               if (store_q) begin
                  out_valid_q    <= 1'b1;
                  out_pc_q       <= pc_q;
                  out_pc_next_q  <= pc_next_q;
                  out_wb_data_q  <= addr_q;
                  out_reg_wen_q  <= 1'b0;
                  out_rd_q       <= '0;
                  out_misalign_q <= 1'b0;
                  state_q        <= IDLE;
               end else begin
                  state_q <= RESP;
               end
            end
            RESP: if (bus.mem_rsp_valid) begin
               out_valid_q    <= 1'b1;
               out_pc_q       <= pc_q;
               out_pc_next_q  <= pc_next_q;
               out_wb_data_q  <= load_d;
               out_reg_wen_q  <= reg_wen_q;
               out_rd_q       <= reg_wen_q ? rd_q : '0;
               out_misalign_q <= 1'b0;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = (state_q == IDLE);
   assign bus.mem_req_valid = (state_q == REQ) && !rst;
   assign bus.mem_req_addr  = {addr_q[DATA_WIDTH-1:3], 3'b000};
   assign bus.mem_req_we    = store_q;
   assign bus.mem_req_wdata = wdata_q;
   assign bus.mem_req_wmask = wmask_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_pc        = out_pc_q;
   assign bus.out_pc_next   = out_pc_next_q;
   assign bus.out_wb_data   = out_wb_data_q;
   assign bus.out_rd        = out_rd_q;
   assign bus.out_reg_wen   = out_reg_wen_q;
   assign bus.out_misalign  = out_misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of the MEM stage against a byte-level reference model.
module tb_mem_access_stage;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] last_pc;

   always #5 clk = ~clk;

   mem_access_stage_if #(.DATA_WIDTH(64), .RF_SIZE(5)) bus ();
   mem_access_stage #(.DATA_WIDTH(64), .RF_SIZE(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned nbytes(input logic [2:0] det);
      return 32'd1 << det[1:0];
   endfunction

   function automatic logic misaligned(input logic [63:0] addr, input logic [2:0] det);
      return (int'(addr[2:0]) % nbytes(det)) != 0;
   endfunction

   function automatic logic [7:0] model_wmask(input logic [63:0] addr, input logic [2:0] det);
      logic [7:0] m = '0;
      for (int i = 0; i < int'(nbytes(det)); i++)
         if (int'(addr[2:0]) + i < 8) m[int'(addr[2:0]) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                              input logic [2:0] det);
      logic [63:0] v = '0;
      int n = int'(nbytes(det));
      int off = int'(addr[2:0]);
      for (int i = 0; i < n; i++)
         if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!det[2] && n < 8 && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic scramble_inputs();
      bus.in_pc         = {$urandom, $urandom};
      bus.in_pc_next    = {$urandom, $urandom};
      bus.in_alu_result = {$urandom, $urandom};
      bus.in_store_data = {$urandom, $urandom};
      bus.in_rd         = 5'($urandom);
      bus.in_reg_wen    = 1'($urandom);
      bus.in_mem_ren    = 1'($urandom);
      bus.in_mem_wen    = 1'($urandom);
      bus.in_detail     = 3'($urandom);
   endtask

   task automatic run_op(input logic [63:0] pc, input logic [63:0] pcn, input logic [63:0] alu,
                         input logic [63:0] sd, input logic [4:0] rd, input logic wen,
                         input logic ren, input logic mwen, input logic [2:0] det,
                         input logic [63:0] rdata, input int rdly, input int sdly);
      logic is_mem, mis, is_st;
      is_mem = ren | mwen;
      mis    = is_mem && misaligned(alu, det);
      is_st  = mwen;
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_pc = pc; bus.in_pc_next = pcn; bus.in_alu_result = alu; bus.in_store_data = sd;
      bus.in_rd = rd; bus.in_reg_wen = wen; bus.in_mem_ren = ren; bus.in_mem_wen = mwen;
      bus.in_detail = det; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      scramble_inputs();
      if (!is_mem || mis) begin
         check("alu_out_valid", 64'(bus.out_valid), 64'd1);
         check("alu_wb_data", bus.out_wb_data, alu);
         check("alu_rd", 64'(bus.out_rd), (wen && !is_mem) ? 64'(rd) : 64'd0);
         check("alu_reg_wen", 64'(bus.out_reg_wen), 64'(wen && !is_mem));
         check("alu_misalign", 64'(bus.out_misalign), 64'(mis));
         check("alu_pc", bus.out_pc, pc);
         check("alu_pc_next", bus.out_pc_next, pcn);
         check("alu_no_req", 64'(bus.mem_req_valid), 64'd0);
      end else begin
         for (int k = 0; k <= rdly; k++) begin
            check("req_valid", 64'(bus.mem_req_valid), 64'd1);
            check("req_addr", bus.mem_req_addr, alu & ~64'h7);
            check("req_we", 64'(bus.mem_req_we), 64'(is_st));
            if (is_st) begin
               check("req_wdata", bus.mem_req_wdata, sd << (8 * int'(alu[2:0])));
               check("req_wmask", 64'(bus.mem_req_wmask), 64'(model_wmask(alu, det)));
            end
            check("req_in_ready", 64'(bus.in_ready), 64'd0);
            check("req_out_valid", 64'(bus.out_valid), 64'd0);
            bus.mem_req_ready = (k == rdly);
            bus.mem_rsp_valid = 1'($urandom);
            bus.mem_rsp_rdata = {$urandom, $urandom};
            tick();
         end
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         if (is_st) begin
            check("st_out_valid", 64'(bus.out_valid), 64'd1);
            check("st_reg_wen", 64'(bus.out_reg_wen), 64'd0);
            check("st_rd", 64'(bus.out_rd), 64'd0);
            check("st_pc", bus.out_pc, pc);
            check("st_misalign", 64'(bus.out_misalign), 64'd0);
         end else begin
            for (int k = 0; k <= sdly; k++) begin
               check("rsp_out_valid", 64'(bus.out_valid), 64'd0);
               check("rsp_req_valid", 64'(bus.mem_req_valid), 64'd0);
               check("rsp_in_ready", 64'(bus.in_ready), 64'd0);
               bus.mem_rsp_valid = (k == sdly);
               bus.mem_rsp_rdata = (k == sdly) ? rdata : {$urandom, $urandom};
               tick();
            end
            bus.mem_rsp_valid = 1'b0;
            check("ld_out_valid", 64'(bus.out_valid), 64'd1);
            check("ld_wb_data", bus.out_wb_data, model_load(rdata, alu, det));
            check("ld_reg_wen", 64'(bus.out_reg_wen), 64'(wen));
            check("ld_rd", 64'(bus.out_rd), wen ? 64'(rd) : 64'd0);
            check("ld_pc", bus.out_pc, pc);
            check("ld_pc_next", bus.out_pc_next, pcn);
            check("ld_misalign", 64'(bus.out_misalign), 64'd0);
         end
      end
      last_pc = pc;
   endtask

   task automatic idle_cycle();
      bus.mem_rsp_valid = 1'($urandom);
      bus.mem_rsp_rdata = {$urandom, $urandom};
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("idle_pc_hold", bus.out_pc, last_pc);
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic [2:0]  det;
      logic [63:0] alu;
      int          kind;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      scramble_inputs();
      repeat (3) tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
      check("rst_reg_wen", 64'(bus.out_reg_wen), 64'd0);
      check("rst_misalign", 64'(bus.out_misalign), 64'd0);
      check("rst_pc", bus.out_pc, 64'd0);
      check("rst_pc_next", bus.out_pc_next, 64'd0);
      check("rst_wb_data", bus.out_wb_data, 64'd0);
      check("rst_rd", 64'(bus.out_rd), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b0;
      last_pc = '0;
      idle_cycle();

      run_op(64'h100, 64'h104, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 64'h0, 0, 0);
      check("add_rd5", 64'(bus.out_rd), 64'd5);
      run_op(64'h104, 64'h108, 64'h1003, 64'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000,
             64'h0000_0000_8000_0000, 0, 1);
      check("lb_value", bus.out_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
      run_op(64'h108, 64'h10C, 64'h1003, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b100,
             64'h0000_0000_8000_0000, 1, 0);
      check("lbu_value", bus.out_wb_data, 64'h80);
      run_op(64'h10C, 64'h110, 64'h2006, 64'hABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 64'h0, 3, 0);
      run_op(64'h110, 64'h114, 64'h3002, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 64'h0, 0, 0);
      check("lw_misalign", 64'(bus.out_misalign), 64'd1);
      run_op(64'h114, 64'h118, 64'h4004, 64'h1122_3344, 5'd9, 1'b1, 1'b1, 1'b1, 3'b010, 64'h0, 1, 0);
      run_op(64'h118, 64'h11C, 64'h5004, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b011, 64'h0, 0, 0);
      idle_cycle();

      run_op(64'h200, 64'h204, 64'h11, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h0, 0, 0);
      run_op(64'h204, 64'h208, 64'h6000, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b011,
             64'hDEAD_BEEF_0123_4567, 0, 2);
      run_op(64'h208, 64'h20C, 64'h22, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 64'h0, 0, 0);
      idle_cycle();

      bus.in_pc = 64'h300; bus.in_pc_next = 64'h304; bus.in_alu_result = 64'h7000;
      bus.in_rd = 5'd4; bus.in_reg_wen = 1'b1; bus.in_mem_ren = 1'b1; bus.in_mem_wen = 1'b0;
      bus.in_detail = 3'b011; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("rstx_req_valid", 64'(bus.mem_req_valid), 64'd1);
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      check("rstx_in_resp", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstx_in_ready", 64'(bus.in_ready), 64'd1);
      check("rstx_out_valid", 64'(bus.out_valid), 64'd0);
      check("rstx_wb_data", bus.out_wb_data, 64'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = {$urandom, $urandom};
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("late_rsp_out_valid", 64'(bus.out_valid), 64'd0);
      check("late_rsp_in_ready", 64'(bus.in_ready), 64'd1);
      check("late_rsp_req_valid", 64'(bus.mem_req_valid), 64'd0);
      last_pc = '0;
      idle_cycle();

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 3));
         det  = 3'($urandom);
         alu  = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) alu = alu & ~64'(nbytes(det) - 1);
         run_op({$urandom, $urandom}, {$urandom, $urandom}, alu, {$urandom, $urandom},
                5'($urandom), 1'($urandom), kind == 1 || kind == 3, kind >= 2, det,
                {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 4) == 0) idle_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
